// File: rtl/seq_mul_ctrl_pkg.sv
// Shared definitions for the sequential multiplier: controller state encodings,
// step-counter mux select codes and the packed control vector.
package seq_mul_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        COMPUTE = 2'b10,
        DONE    = 2'b11
    } state_t;

    // Counter select codes are {cnt_keep, cnt_inc}
    localparam logic [1:0] CNT_CLR  = 2'b00;
    localparam logic [1:0] CNT_INC  = 2'b11;
    localparam logic [1:0] CNT_HOLD = 2'b10;

    typedef struct packed {
        logic       load_en;
        logic       acc_clr;
        logic       acc_wren;
        logic       shift_en;
        logic [1:0] cnt_sel;
        logic       cnt_wren;
        logic       busy;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/seq_mul_ctrl_decode.sv
// Moore output decoder: maps controller state (plus the current B bit) onto the
// datapath control vector. Purely combinational.
module seq_mul_ctrl_decode
    import seq_mul_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   opb_bit,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            LOAD: begin
                ctrl.load_en  = 1'b1;
                ctrl.acc_clr  = 1'b1;
                ctrl.cnt_sel  = CNT_CLR;
                ctrl.cnt_wren = 1'b1;
                ctrl.busy     = 1'b1;
            end
            COMPUTE: begin
                ctrl.shift_en = 1'b1;
                ctrl.acc_wren = opb_bit;
                ctrl.cnt_sel  = CNT_INC;
                ctrl.cnt_wren = 1'b1;
                ctrl.busy     = 1'b1;
            end
            // Counter is not written in DONE, so it simply holds its value
            DONE: begin
                ctrl.done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/seq_mul_ctrl.sv
// Control FSM for the shift-and-add sequential multiplier: holds the state
// register and next-state logic; output decoding lives in seq_mul_ctrl_decode.
module seq_mul_ctrl
    import seq_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             ack,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
    input  logic             opb_bit,
    output logic             load_en,
    output logic             acc_clr,
    output logic             acc_wren,
    output logic             shift_en,
    output logic             cnt_keep,
    output logic             cnt_inc,
    output logic             cnt_wren,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort wins over every other transition, including start in IDLE
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = LOAD;
                LOAD:    state_next = COMPUTE;
                COMPUTE: if (count == LAST_STEP) state_next = DONE;
                DONE:    if (ack) state_next = start ? LOAD : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    seq_mul_ctrl_decode u_decode (
        .state   (state),
        .opb_bit (opb_bit),
        .ctrl    (ctrl)
    );

    assign load_en  = ctrl.load_en;
    assign acc_clr  = ctrl.acc_clr;
    assign acc_wren = ctrl.acc_wren;
    assign shift_en = ctrl.shift_en;
    assign cnt_keep = ctrl.cnt_sel[1];
    assign cnt_inc  = ctrl.cnt_sel[0];
    assign cnt_wren = ctrl.cnt_wren;
    assign busy     = ctrl.busy;
    assign done     = ctrl.done;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed bench for seq_mul_ctrl, with a small step-counter and shift-and-add
// datapath around it so the product can be checked end to end.
module tb_seq_mul_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, ack, abort;
    logic [1:0] count;
    logic       opb_bit;
    logic       load_en, acc_clr, acc_wren, shift_en;
    logic       cnt_keep, cnt_inc, cnt_wren, busy, done;

    logic [3:0] a_in, b_in;
    logic [7:0] a_reg, acc;
    logic [3:0] b_reg;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] V_IDLE = 9'b000000000;
    localparam logic [8:0] V_LOAD = 9'b110000110;
    localparam logic [8:0] V_DONE = 9'b000000001;

    wire [8:0] obs = {load_en, acc_clr, acc_wren, shift_en, cnt_keep, cnt_inc,
                      cnt_wren, busy, done};

    always #5 clk = ~clk;

    seq_mul_ctrl #(.WIDTH(4), .CNT_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .ack      (ack),
        .abort    (abort),
        .count    (count),
        .opb_bit  (opb_bit),
        .load_en  (load_en),
        .acc_clr  (acc_clr),
        .acc_wren (acc_wren),
        .shift_en (shift_en),
        .cnt_keep (cnt_keep),
        .cnt_inc  (cnt_inc),
        .cnt_wren (cnt_wren),
        .busy     (busy),
        .done     (done)
    );

    // Step counter and datapath as the parent would build them
    assign opb_bit = b_reg[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            if (cnt_wren) count <= (cnt_keep ? count : 2'd0) + (cnt_inc ? 2'd1 : 2'd0);
            if (load_en) begin
                a_reg <= {4'd0, a_in};
                b_reg <= b_in;
            end else if (shift_en) begin
                a_reg <= a_reg << 1;
                b_reg <= b_reg >> 1;
            end
            if (acc_clr) acc <= '0;
            else if (acc_wren) acc <= acc + a_reg;
        end
    end

    function automatic logic [8:0] v_compute(input logic opb);
        return {2'b00, opb, 6'b111110};
    endfunction

    // Drives start at the current negedge and follows LOAD, 4 COMPUTE steps,
    // ending at the negedge where DONE is visible.
    task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] wren_seq, input logic [7:0] prod);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== V_LOAD) begin
            errors++;
            $display("[TB] FAIL %s load: got %b want %b", name, obs, V_LOAD);
        end
        start = 1'b0;
        ack   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== v_compute(wren_seq[i]) || count !== 2'(i)) begin
                errors++;
                $display("[TB] FAIL %s step%0d: got %b cnt %0d want %b cnt %0d",
                         name, i, obs, count, v_compute(wren_seq[i]), i);
            end
        end
        @(negedge clk);
        checks++;
        if (obs !== V_DONE || acc !== prod) begin
            errors++;
            $display("[TB] FAIL %s done: got %b prod %0d want %b prod %0d",
                     name, obs, acc, V_DONE, prod);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 0; ack = 0; abort = 0; a_in = 0; b_in = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_init: got %b want %b", obs, V_IDLE);
        end
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        a_in = 4'd5; b_in = 4'd7;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (count !== 2'd2 || obs !== v_compute(1'b1)) begin
            errors++;
            $display("[TB] FAIL reset_pre: got %b cnt %0d want %b cnt 2", obs, count, v_compute(1'b1));
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_mid: got %b want %b", obs, V_IDLE);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b want %b", obs, V_IDLE);
        end
    endtask

    task automatic test_multiply();
        run_op("mul_3x11", 4'b0011, 4'b1011, 4'b1011, 8'd33);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL mul_ack_idle: got %b want %b", obs, V_IDLE);
        end
        run_op("mul_bzero", 4'b1111, 4'b0000, 4'b0000, 8'd0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        run_op("mul_15x15", 4'hF, 4'hF, 4'b1111, 8'd225);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 4'b0011, 4'b1011, 4'b1011, 8'd33);
        ack = 1'b1;
        run_op("b2b_second", 4'd7, 4'b1001, 4'b1001, 8'd63);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got %b want %b", obs, V_IDLE);
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        run_op("hold_op", 4'd5, 4'b0101, 4'b0101, 8'd25);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            @(negedge clk);
            if (obs !== V_DONE || acc !== 8'd25) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL hold: %0d bad cycles, last got %b want %b", bad, obs, V_DONE);
        end
        start = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_abort();
        int bad = 0;
        a_in = 4'd6; b_in = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (count !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_pre: got cnt %0d busy %b want cnt 1 busy 1", count, busy);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL abort_compute: got %b want %b", obs, V_IDLE);
        end
        // Still asserting abort with start in IDLE must keep the FSM idle
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL abort_idle: got %b want %b", obs, V_IDLE);
        end
        abort = 1'b0;
        start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL abort_after: %0d bad cycles got %b want %b", bad, obs, V_IDLE);
        end
        run_op("abort_done_op", 4'd2, 4'd2, 4'b0010, 8'd4);
        abort = 1'b1;
        ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0; ack = 1'b0; start = 1'b0;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL abort_done: got %b want %b", obs, V_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_back_to_back();
        test_hold();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
